// File: rtl/load_store_unit.sv
// Load/store unit between a scalar core and a word-organised data memory.
// Sub-word stores are done as read-modify-write; all memory and response outputs are registered.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_enable,
  output logic        mem_readwrite,
  input  logic [31:0] mem_rdata
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is only high in IDLE out of reset, so nothing is ever queued.

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

  state_t      state;

  logic [31:0] ea;
  logic        ea_err;

  logic        store_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [15:0] addr_q;

  logic        en_q;
  logic        rw_q;
  logic [31:0] wd_q;
  logic        rv_q;
  logic [31:0] rdata_q;
  logic        err_q;

  assign ea = req_base + req_offset;

  always_comb begin
    ea_err = 1'b0;
    case (req_size)
      2'b01:   ea_err = ea[0];
      2'b10:   ea_err = |ea[1:0];
      2'b11:   ea_err = 1'b1;
      default: ea_err = 1'b0;
    endcase
    if (|ea[31:18]) ea_err = 1'b1;
  end

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return w;
    endcase
  endfunction

  // Replace only the addressed byte/halfword of the captured word.
  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: r[{ln, 3'b000} +: 8] = d[7:0];
      2'b01: begin
        if (ln[1]) r[31:16] = d[15:0];
        else       r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      store_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      wdata_q <= 32'd0;
      addr_q  <= 16'd0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      wd_q    <= 32'd0;
      rv_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      en_q <= 1'b0;
      rw_q <= 1'b0;
      rv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            store_q <= req_store;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= ea[1:0];
            wdata_q <= req_wdata;
            addr_q  <= ea[17:2];
            if (ea_err) begin
              state   <= RESP;
              rv_q    <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else if (req_store && req_size == 2'b10) begin
              state <= WRITE;
              en_q  <= 1'b1;
              rw_q  <= 1'b1;
              wd_q  <= req_wdata;
            end else begin
              state <= READ;
              en_q  <= 1'b1;
            end
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          // mem_rdata is valid here, one cycle after the read strobe.
          if (store_q) begin
            state <= WRITE;
            en_q  <= 1'b1;
            rw_q  <= 1'b1;
            wd_q  <= merge_store(mem_rdata, wdata_q, size_q, lane_q);
          end else begin
            state   <= RESP;
            rv_q    <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= load_extend(mem_rdata, size_q, lane_q, uns_q);
          end
        end
        WRITE: begin
          state   <= RESP;
          rv_q    <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are masked by rst so an edge that aborts an operation can never write memory.
  assign req_ready     = (state == IDLE) && !rst;
  assign mem_enable    = en_q & ~rst;
  assign mem_readwrite = rw_q & ~rst;
  assign mem_wdata     = mem_readwrite ? wd_q : 32'd0;
  assign mem_addr      = rst ? 32'd0 : {16'd0, addr_q};
  assign rsp_valid     = rv_q & ~rst;
  assign rsp_rdata     = rst ? 32'd0 : rdata_q;
  assign rsp_err       = err_q & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64K x 32 registered-read data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_enable;
  logic        mem_readwrite;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:65535];

  int total = 0;
  int bad   = 0;

  int          obs_rd, obs_wr, obs_rsp, obs_en;
  logic [31:0] obs_wa, obs_wd, obs_rdata;
  logic        obs_err;
  int          wd_viol = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_enable(mem_enable),
    .mem_readwrite(mem_readwrite), .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural data memory
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_readwrite) mem[mem_addr[15:0]] <= mem_wdata;
      else               mem_rdata <= mem[mem_addr[15:0]];
    end
  end

  always @(negedge clk) begin
    if (!mem_readwrite && mem_wdata !== 32'd0) wd_viol++;
  end

  // driver: present one request at a negedge, record strobes and response per cycle
  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] w);
    int guard;
    req_store = st; req_size = sz; req_unsigned = un;
    req_base = b; req_offset = o; req_wdata = w;
    req_valid = 1'b1;
    obs_rd = -1; obs_wr = -1; obs_rsp = -1; obs_en = 0;
    obs_wa = 32'hx; obs_wd = 32'hx; obs_rdata = 32'hx; obs_err = 1'bx;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (mem_enable) obs_en++;
      if (mem_enable && !mem_readwrite && obs_rd < 0) obs_rd = k;
      if (mem_enable && mem_readwrite) begin
        obs_wr = k; obs_wa = mem_addr; obs_wd = mem_wdata;
      end
      if (rsp_valid) begin
        obs_rsp = k; obs_rdata = rsp_rdata; obs_err = rsp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_base = 32'd0; req_offset = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    total++;
    if ({rsp_valid, rsp_err, mem_enable, mem_readwrite} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {rsp_valid, rsp_err, mem_enable, mem_readwrite});
    end
    total++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {rsp_rdata, mem_addr, mem_wdata});
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
  endtask

  task automatic test_word_store_load();
    @(negedge clk);
    issue(1'b1, 2'b10, 1'b0, 32'd0, 32'd4, 32'hFFFF_FFFF);
    total++;
    if (obs_wr !== 1 || obs_rsp !== 2 || obs_rd !== -1) begin
      bad++; $display("FAIL sw_timing got wr=%0d rsp=%0d rd=%0d exp 1 2 -1", obs_wr, obs_rsp, obs_rd);
    end
    total++;
    if (obs_wa !== 32'd1 || obs_wd !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sw_strobe got addr=%h data=%h exp 1 ffffffff", obs_wa, obs_wd);
    end
    total++;
    if (obs_err !== 1'b0 || obs_rdata !== 32'd0 || mem[1] !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sw_result got err=%b rdata=%h mem1=%h exp 0 0 ffffffff", obs_err, obs_rdata, mem[1]);
    end
    issue(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 32'd0);
    total++;
    if (obs_rd !== 1 || obs_rsp !== 3 || obs_rdata !== 32'hFFFF_FFFF || obs_err !== 1'b0) begin
      bad++; $display("FAIL lw got rd=%0d rsp=%0d data=%h err=%b exp 1 3 ffffffff 0", obs_rd, obs_rsp, obs_rdata, obs_err);
    end
  endtask

  task automatic test_subword_load();
    mem[1] = 32'h0000_80F0;
    issue(1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 32'd0);
    total++;
    if (obs_rdata !== 32'hFFFF_FF80 || obs_rsp !== 3) begin
      bad++; $display("FAIL lb_signed got=%h rsp=%0d exp ffffff80 3", obs_rdata, obs_rsp);
    end
    issue(1'b0, 2'b00, 1'b1, 32'd5, 32'd0, 32'd0);
    total++;
    if (obs_rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu got=%h exp 00000080", obs_rdata); end
    issue(1'b0, 2'b01, 1'b0, 32'd6, 32'd0, 32'd0);
    total++;
    if (obs_rdata !== 32'h0000_0000) begin bad++; $display("FAIL lh_ea6 got=%h exp 00000000", obs_rdata); end
    issue(1'b0, 2'b01, 1'b0, 32'd4, 32'd0, 32'd0);
    total++;
    if (obs_rdata !== 32'hFFFF_80F0) begin bad++; $display("FAIL lh_ea4 got=%h exp ffff80f0", obs_rdata); end
  endtask

  task automatic test_subword_store();
    mem[1] = 32'h1122_3344;
    issue(1'b1, 2'b00, 1'b0, 32'd6, 32'd0, 32'h0000_00AB);
    total++;
    if (obs_rd !== 1 || obs_wr !== 3 || obs_rsp !== 4) begin
      bad++; $display("FAIL sb_timing got rd=%0d wr=%0d rsp=%0d exp 1 3 4", obs_rd, obs_wr, obs_rsp);
    end
    total++;
    if (obs_wd !== 32'h11AB_3344 || mem[1] !== 32'h11AB_3344) begin
      bad++; $display("FAIL sb_data got wd=%h mem1=%h exp 11ab3344", obs_wd, mem[1]);
    end
    issue(1'b1, 2'b01, 1'b0, 32'd4, 32'd2, 32'hDEAD_BEEF);
    total++;
    if (mem[1] !== 32'hBEEF_3344 || obs_rsp !== 4) begin
      bad++; $display("FAIL sh_data got mem1=%h rsp=%0d exp beef3344 4", mem[1], obs_rsp);
    end
  endtask

  task automatic test_offsets_errors();
    logic [31:0] eb [4];
    logic [31:0] eo [4];
    logic [1:0]  es [4];
    mem[2] = 32'hCAFE_0123;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'hFFFF_FFF8, 32'd0);
    total++;
    if (obs_rdata !== 32'hCAFE_0123 || obs_err !== 1'b0) begin
      bad++; $display("FAIL neg_offset got=%h err=%b exp cafe0123 0", obs_rdata, obs_err);
    end
    eb[0] = 32'd3;          eo[0] = 32'd0; es[0] = 2'b01;
    eb[1] = 32'd0;          eo[1] = 32'd2; es[1] = 2'b10;
    eb[2] = 32'h0004_0000;  eo[2] = 32'd0; es[2] = 2'b00;
    eb[3] = 32'd8;          eo[3] = 32'd0; es[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, es[i], 1'b0, eb[i], eo[i], 32'd0);
      total++;
      if (obs_rsp !== 1 || obs_err !== 1'b1 || obs_en !== 0 || obs_rdata !== 32'd0) begin
        bad++; $display("FAIL err_case%0d got rsp=%0d err=%b en=%0d rdata=%h exp 1 1 0 0",
                        i, obs_rsp, obs_err, obs_en, obs_rdata);
      end
    end
    issue(1'b1, 2'b10, 1'b0, 32'd0, 32'd1, 32'h1234_5678);
    total++;
    if (obs_rsp !== 1 || obs_err !== 1'b1 || obs_en !== 0) begin
      bad++; $display("FAIL err_store got rsp=%0d err=%b en=%0d exp 1 1 0", obs_rsp, obs_err, obs_en);
    end
  endtask

  task automatic test_reset_abort();
    int rsp_seen;
    rsp_seen = 0;
    @(negedge clk);
    mem[1] = 32'h1122_3344;
    req_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_base = 32'd6; req_offset = 32'd0; req_wdata = 32'h0000_00AB;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (!(mem_enable && mem_readwrite)) begin
      bad++; $display("FAIL abort_in_write got en=%b rw=%b exp 1 1", mem_enable, mem_readwrite);
    end
    rst = 1'b1;
    #1;
    total++;
    if (mem_enable !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL abort_rst_outputs got en=%b ready=%b exp 0 0", mem_enable, req_ready);
    end
    @(negedge clk);
    if (rsp_valid) rsp_seen++;
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    total++;
    if (rsp_seen !== 0 || mem[1] !== 32'h1122_3344) begin
      bad++; $display("FAIL abort_effect got rsp=%0d mem1=%h exp 0 11223344", rsp_seen, mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    int acc, rsps, rbad;
    acc = 0; rsps = 0; rbad = 0;
    mem[3] = 32'h5A5A_0F0F;
    req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_base = 32'd12; req_offset = 32'd0; req_wdata = 32'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_valid && req_ready) acc++;
      if (rsp_valid) begin
        rsps++;
        if (rsp_rdata !== 32'h5A5A_0F0F || rsp_err !== 1'b0) rbad++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    total++;
    if (acc !== 3 || rsps !== 3) begin
      bad++; $display("FAIL b2b_count got acc=%0d rsp=%0d exp 3 3", acc, rsps);
    end
    total++;
    if (rbad !== 0) begin bad++; $display("FAIL b2b_data got bad=%0d exp 0", rbad); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem_rdata = 32'd0;
    test_reset();
    test_word_store_load();
    test_subword_load();
    test_subword_store();
    test_offsets_errors();
    test_reset_abort();
    test_back_to_back();
    total++;
    if (wd_viol !== 0) begin bad++; $display("FAIL wdata_when_read got=%0d exp 0", wd_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_base  in  32  base register value
- req_offset  in  32  sign-extended immediate
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result, extended
- rsp_err  out  1  request rejected, no memory access
- mem_addr  out  32  word address to data memory
- mem_wdata  out  32  write word to data memory
- mem_enable  out  1  memory access strobe
- mem_readwrite  out  1  0 = read, 1 = write
- mem_rdata  in  32  data memory read word; valid the cycle after a read strobe

Function
REQ-003 The block SHALL compute the effective address as ea = req_base + req_offset, modulo 2^32, when it accepts a request.
REQ-004 mem_addr SHALL be {16'b0, ea[17:2]}, and the byte lane SHALL be ea[1:0], little-endian: lane n occupies bits [8n+7:8n].
REQ-005 A request SHALL be flagged as an error when any of the following holds: req_size = 11; a halfword with ea[0] = 1; a word with ea[1:0] != 0; or ea[31:18] != 0.
REQ-006 The FSM states SHALL be IDLE, READ, CAPTURE, WRITE and RESP.
REQ-007 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted when req_valid && req_ready, and all request fields SHALL be latched at acceptance.
REQ-008 IDLE transitions SHALL be:
- error -> RESP
- word store -> WRITE
- any load or sub-word store -> READ
REQ-009 In READ, the block SHALL drive mem_enable = 1 and mem_readwrite = 0 for one cycle, then go to CAPTURE.
REQ-010 CAPTURE SHALL register mem_rdata, then go to RESP for a load or WRITE for a store.
REQ-011 In WRITE, the block SHALL drive mem_enable = 1 and mem_readwrite = 1 for one cycle, then go to RESP.
- Word store: mem_wdata = req_wdata.
- Sub-word store: mem_wdata = the captured word with only the addressed byte or halfword replaced by req_wdata[7:0] or [15:0].
REQ-012 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
- rsp_rdata and rsp_err SHALL be updated on entry to RESP and held until the next RESP.
REQ-013 Load result: the selected lane SHALL be extended per req_unsigned to 32 bits; a word load returns the word unchanged.
- Stores and errors SHALL return rsp_rdata = 0.
REQ-014 Latency from the accept edge to rsp_valid SHALL be:
- word or sub-word load: 3 cycles
- word store: 2 cycles
- sub-word store: 4 cycles
- error: 1 cycle
REQ-015 mem_enable SHALL be 0 in IDLE, CAPTURE and RESP, and whenever rst = 1.
- mem_wdata SHALL be 0 whenever mem_readwrite = 0.
REQ-016 req_valid asserted outside IDLE SHALL be ignored; no request is queued.
REQ-017 Back-to-back requests SHALL be supported: a request presented during the RESP cycle is accepted on the cycle after RESP, in IDLE.

Reset
REQ-018 While rst = 1 the block SHALL force:
- state = IDLE
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
- mem_enable = 0, mem_readwrite = 0, mem_addr = 0, mem_wdata = 0
- req_ready = 0
REQ-019 rst asserted in any state SHALL abort the operation at that edge with no memory write and no rsp_valid.
- An aborted sub-word store SHALL leave memory unchanged.
REQ-020 The first request SHALL be acceptable in the cycle after rst deasserts.

Verification
REQ-021 The bench SHALL use a behavioural data memory (65536 x 32, registered read) and cover these directed scenarios:
- Word store, base = 0, offset = 4, wdata = FFFFFFFF -> write strobe at word 1 on cycle 1, rsp_valid on cycle 2; a following word load at ea 4 returns FFFFFFFF.
- Memory word 1 = 000080F0: byte load at ea 5, signed -> FFFFFF80; unsigned -> 00000080; halfword load at ea 6 -> 00000000; halfword load at ea 4, signed -> FFFF80F0.
- Memory word 1 = 11223344: byte store of AB at ea 6 -> memory word 1 becomes 11AB3344, with the read strobe, then the write strobe, then rsp_valid 4 cycles after accept.
- Negative offset: base = 10, offset = FFFFFFF8 gives ea = 8 and a word load from word 2; halfword at ea 3, word at ea 2, ea = 00040000, and size 11 each give rsp_err = 1 after 1 cycle with no mem_enable.
- rst pulsed in the WRITE state of a byte store -> memory unchanged, no rsp_valid, req_ready = 1 on the cycle after rst falls.
- req_valid held high continuously -> consecutive requests are accepted only in IDLE, with no lost or duplicated responses.
